// File: rtl/p_bit_cell_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// p_bit_cell_if : sequencer/datapath-facing signal bundle of one p-bit cell
// Revision 1.0
// ---------------------------------------------------------------------------
interface p_bit_cell_if;
    logic               enable;
    logic signed [7:0]  I_i;
    logic        [31:0] seed;
    logic               m_i;
    logic signed [7:0]  rnd;

    modport master (output enable, I_i, seed, input m_i, rnd);
    modport slave  (input enable, I_i, seed, output m_i, rnd);
endinterface
`default_nettype wire

// File: rtl/p_bit_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// p_bit_cell : probabilistic bit, tanh activation compared against xorshift32
// Revision 1.0
// ---------------------------------------------------------------------------
module p_bit_cell #(
    parameter logic [31:0] SEED_FALLBACK = 32'hDEADBEEF
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    p_bit_cell_if.slave     bus
);

    logic        [31:0] state;
    logic               m_reg;
    logic        [7:0]  idx;
    logic signed [7:0]  act;
    logic signed [7:0]  r;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] a;
        logic [31:0] b;
        a = x ^ (x << 13);
        b = a ^ (a >> 17);
        return b ^ (b << 5);
    endfunction

    assign idx = bus.I_i;
    assign r   = state[31:24];

    // round(128*tanh(I/8)); positive side saturates at 127 from I=21,
    // negative side reaches -128 from I=-25
    always_comb begin
        act = 8'sd0;
        case (idx)
            8'd0:   act =  8'sd0;
            8'd1:   act =  8'sd16;
            8'd2:   act =  8'sd31;
            8'd3:   act =  8'sd46;
            8'd4:   act =  8'sd59;
            8'd5:   act =  8'sd71;
            8'd6:   act =  8'sd81;
            8'd7:   act =  8'sd90;
            8'd8:   act =  8'sd97;
            8'd9:   act =  8'sd104;
            8'd10:  act =  8'sd109;
            8'd11:  act =  8'sd113;
            8'd12:  act =  8'sd116;
            8'd13:  act =  8'sd118;
            8'd14:  act =  8'sd120;
            8'd15:  act =  8'sd122;
            8'd16:  act =  8'sd123;
            8'd17:  act =  8'sd124;
            8'd18:  act =  8'sd125;
            8'd19:  act =  8'sd126;
            8'd20:  act =  8'sd126;
            8'd255: act = -8'sd16;
            8'd254: act = -8'sd31;
            8'd253: act = -8'sd46;
            8'd252: act = -8'sd59;
            8'd251: act = -8'sd71;
            8'd250: act = -8'sd81;
            8'd249: act = -8'sd90;
            8'd248: act = -8'sd97;
            8'd247: act = -8'sd104;
            8'd246: act = -8'sd109;
            8'd245: act = -8'sd113;
            8'd244: act = -8'sd116;
            8'd243: act = -8'sd118;
            8'd242: act = -8'sd120;
            8'd241: act = -8'sd122;
            8'd240: act = -8'sd123;
            8'd239: act = -8'sd124;
            8'd238: act = -8'sd125;
            8'd237: act = -8'sd126;
            8'd236: act = -8'sd126;
            8'd235: act = -8'sd127;
            8'd234: act = -8'sd127;
            8'd233: act = -8'sd127;
            8'd232: act = -8'sd127;
            default: act = idx[7] ? -8'sd128 : 8'sd127;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state <= (bus.seed == 32'd0) ? SEED_FALLBACK : bus.seed;
            m_reg <= 1'b0;
        end else if (bus.enable) begin
            m_reg <= (act > r);
            state <= xorshift32(state);
        end
    end

    assign bus.m_i = m_reg;
    assign bus.rnd = r;

endmodule
`default_nettype wire

// File: tb/tb_p_bit_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_p_bit_cell : directed and statistical checks against an xorshift/tanh model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_p_bit_cell;

    localparam logic [31:0] FALLBACK = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] ms;
    logic        mm;

    p_bit_cell_if bus();

    p_bit_cell #(.SEED_FALLBACK(FALLBACK)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    function automatic int act_ref(input int i);
        real v;
        int  t;
        v = 128.0 * $tanh(real'(i) / 8.0);
        if (v >= 0.0) t = $rtoi(v + 0.5);
        else          t = -$rtoi(0.5 - v);
        if (t > 127)  t = 127;
        if (t < -128) t = -128;
        return t;
    endfunction

    function automatic int rnd_of(input logic [31:0] s);
        logic signed [7:0] b;
        b = s[31:24];
        return int'(b);
    endfunction

    // One clock: drive away from the edge, advance the model, settle
    task automatic step(input logic en, input logic rst, input int iv);
        @(negedge clk);
        bus.enable = en;
        reset_n    = rst;
        bus.I_i    = iv[7:0];
        @(posedge clk);
        if (rst) begin
            ms = (bus.seed == 32'd0) ? FALLBACK : bus.seed;
            mm = 1'b0;
        end else if (en) begin
            mm = (act_ref(iv) > rnd_of(ms));
            ms = xs(ms);
        end
        #1;
    endtask

    task automatic test_reset;
        bus.seed = 32'h00000001;
        step(1'b1, 1'b1, 0);
        n_checks++;
        if (bus.m_i !== 1'b0) begin n_fail++; $display("FAIL reset_m got %b want 0", bus.m_i); end
        n_checks++;
        if (bus.rnd !== 8'sh00) begin n_fail++; $display("FAIL reset_rnd got %h want 00", bus.rnd); end
        step(1'b1, 1'b0, 0);
        n_checks++;
        if (bus.m_i !== 1'b0) begin n_fail++; $display("FAIL first_update_m got %b want 0", bus.m_i); end
        n_checks++;
        if (ms !== 32'h00042021 || bus.rnd !== 8'sh00) begin
            n_fail++; $display("FAIL first_update_S model %h rnd %h want 00042021/00", ms, bus.rnd);
        end
    endtask

    task automatic test_fallback;
        bus.seed = 32'h0;
        step(1'b0, 1'b1, 0);
        n_checks++;
        if (bus.rnd !== 8'shDE) begin n_fail++; $display("FAIL fallback_rnd got %h want de", bus.rnd); end
        step(1'b1, 1'b0, 0);
        n_checks++;
        if (bus.m_i !== 1'b1) begin n_fail++; $display("FAIL fallback_m got %b want 1", bus.m_i); end
        n_checks++;
        if (bus.rnd !== ms[31:24]) begin n_fail++; $display("FAIL fallback_adv got %h want %h", bus.rnd, ms[31:24]); end
    endtask

    task automatic test_saturation;
        int  bad;
        int  iv;
        logic exp_m;
        logic [7:0] rprev;
        bus.seed = 32'hCAFEF00D;
        step(1'b0, 1'b1, 0);
        for (int p = 0; p < 2; p++) begin
            iv  = (p == 0) ? -128 : 127;
            bad = 0;
            for (int c = 0; c < 1000; c++) begin
                rprev = ms[31:24];
                step(1'b1, 1'b0, iv);
                exp_m = (iv == 127) ? (rprev != 8'h7F) : 1'b0;
                n_checks++;
                if (bus.m_i !== exp_m || bus.rnd !== ms[31:24]) begin
                    n_fail++;
                    if (bad < 5) $display("FAIL saturation I=%0d cyc %0d m %b want %b rnd %h want %h",
                                          iv, c, bus.m_i, exp_m, bus.rnd, ms[31:24]);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_hold;
        logic       hm;
        logic [7:0] hr;
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 3);
        hm = mm;
        hr = ms[31:24];
        for (int c = 0; c < 50; c++) begin
            step(1'b0, 1'b0, (c % 2 == 0) ? -128 : 127);
            n_checks++;
            if (bus.m_i !== hm || bus.rnd !== hr) begin
                n_fail++; $display("FAIL hold cyc %0d m %b rnd %h want %b/%h", c, bus.m_i, bus.rnd, hm, hr);
            end
        end
    endtask

    task automatic test_activation_sweep;
        int bad;
        bad = 0;
        bus.seed = 32'h0BADC0DE;
        step(1'b0, 1'b1, 0);
        for (int i = -128; i < 128; i++) begin
            for (int c = 0; c < 4; c++) begin
                step(1'b1, 1'b0, i);
                n_checks++;
                if (bus.m_i !== mm || bus.rnd !== ms[31:24]) begin
                    n_fail++;
                    if (bad < 5) $display("FAIL sweep I=%0d m %b want %b rnd %h want %h",
                                          i, bus.m_i, mm, bus.rnd, ms[31:24]);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_statistics;
        int  ones;
        int  bad;
        int  iv;
        real frac;
        real target;
        bus.seed = 32'h12345678;
        step(1'b0, 1'b1, 0);
        for (int p = 0; p < 3; p++) begin
            iv     = (p == 0) ? 0 : (p == 1) ? 8 : -8;
            target = (p == 0) ? 0.50 : (p == 1) ? 0.88 : 0.12;
            ones = 0;
            bad  = 0;
            for (int c = 0; c < 4096; c++) begin
                step(1'b1, 1'b0, iv);
                if (bus.m_i === 1'b1) ones++;
                n_checks++;
                if (bus.m_i !== mm || bus.rnd !== ms[31:24]) begin
                    n_fail++;
                    if (bad < 5) $display("FAIL stat_exact I=%0d cyc %0d m %b want %b", iv, c, bus.m_i, mm);
                    bad++;
                end
            end
            frac = real'(ones) / 4096.0;
            n_checks++;
            if (frac < target - 0.03 || frac > target + 0.03) begin
                n_fail++; $display("FAIL stat_frac I=%0d got %f want %f+-0.03", iv, frac, target);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic       m_hist [20];
        logic [7:0] r_hist [20];
        bus.seed = 32'h9E3779B9;
        step(1'b0, 1'b1, 0);
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 1'b0, 0);
            m_hist[c] = mm;
            r_hist[c] = ms[31:24];
        end
        for (int c = 0; c < 8 && mm !== 1'b1; c++) step(1'b1, 1'b0, 127);
        n_checks++;
        if (bus.m_i !== 1'b1) begin n_fail++; $display("FAIL mid_pre_m got %b want 1", bus.m_i); end
        step(1'b1, 1'b1, 127);
        n_checks++;
        if (bus.m_i !== 1'b0) begin n_fail++; $display("FAIL mid_reset_m got %b want 0", bus.m_i); end
        n_checks++;
        if (bus.rnd !== 8'sh9E) begin n_fail++; $display("FAIL mid_reset_rnd got %h want 9e", bus.rnd); end
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 1'b0, 0);
            n_checks++;
            if (bus.m_i !== m_hist[c] || bus.rnd !== r_hist[c]) begin
                n_fail++; $display("FAIL mid_repeat cyc %0d m %b rnd %h want %b/%h",
                                   c, bus.m_i, bus.rnd, m_hist[c], r_hist[c]);
            end
        end
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.I_i    = 8'sd0;
        bus.seed   = 32'h0;
        test_reset();
        test_fallback();
        test_saturation();
        test_hold();
        test_activation_sweep();
        test_statistics();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/p_bit_cell.md
Name: p_bit_cell

Overview:
- Single probabilistic bit (p-bit) for the Ising-style probabilistic-computing array.
- Each cell holds a binary state m_i in {0,1}. When enabled, it resamples m_i against a 32-bit xorshift random number, using a tanh-shaped activation of its signed weighted input I_i.
- One instance per network node. The array sequencer drives enable, and the sparse-MAC datapath drives I_i.

Parameters:
- SEED_FALLBACK, 32'hDEADBEEF, substitute RNG state used when the seed input is zero (xorshift cannot leave the all-zero state).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  reset; synchronous, active-high (asserted when 1; the name follows the codebase).
- enable  input  1  update strobe; when 1 at a rising edge, the cell samples and its RNG advances.
- I_i  input  8  signed weighted input, Q4.3 (value = I_i/8, range -16.0..+15.875).
- seed  input  32  RNG seed; sampled only while reset is asserted.
- m_i  output  1  registered p-bit state (1 = up, 0 = down).
- rnd  output  8  signed random sample currently presented to the comparator (state[31:24]); for verification.

Behaviour:
- Registers: 32-bit RNG state S, 1-bit m_i. No other state.
- Reset (reset_n=1 at a rising edge):
  - S <= (seed==0) ? SEED_FALLBACK : seed.
  - m_i <= 0.
  - Reset has priority over enable.
- Idle (reset deasserted, enable=0): S and m_i hold.
- Update (reset deasserted, enable=1), in a single cycle:
  - r = signed S[31:24], range -128..127, representing r/128 in [-1,1).
  - T = activation(I_i), described below.
  - m_i <= (T > r) ? 1 : 0, a strict signed compare.
  - S <= xorshift32(S): x ^= x<<13; x ^= x>>17 (logical); x ^= x<<5, all in 32 bits.
  - The compare uses S before the advance. The new m_i is visible after the edge (latency 1 cycle).
- Activation T (signed 8-bit, Q0.7):
  - T = clamp(round(128*tanh(I_i/8)), -128, +127), rounding half away from zero.
  - Implemented as a combinational 256-entry constant table indexed by I_i. No runtime arithmetic.
  - The table is odd-symmetric except at the clamp: T(0)=0, T(8)=97, T(-8)=-97, T(16)=123, T(-16)=-123, T(127)=127, T(-128)=-128.
  - T is monotonic non-decreasing in I_i.
- Boundary behaviour:
  - I_i=-128: T=-128, so m_i <= 0 always.
  - I_i=127: m_i <= 1 unless r=127.
  - I_i=0: m_i <= 1 exactly when r<0, i.e. S[31]=1.
- Enable asserted on consecutive cycles: one sample and one RNG step per cycle.
- Enable asserted during reset: ignored.
- Reset mid-run: S reloads from the current seed; m_i returns to 0.
- rnd is combinational from S (S[31:24]) and is valid in every cycle.
- S is never zero after reset, so the RNG period is 2^32-1.

Test Plan:
- Reset/seed load: seed=32'h00000001, reset 1 cycle -> m_i=0, rnd=8'h00. Then enable=1 with I_i=0 for 1 cycle -> m_i=0 (0>0 false) and S=32'h00042021.
- Zero-seed fallback: seed=0, reset -> rnd=8'hDE. Then I_i=0 and enable -> m_i=1, because r=-34<0.
- Saturation: I_i=-128, enable for 1000 cycles -> m_i=0 every cycle. I_i=127, 1000 cycles -> m_i=1 except in cycles where rnd=127; the bench checks each against the rnd reference model.
- Hold: after several updates, drop enable for 50 cycles with I_i toggling between -128 and 127 -> m_i and rnd unchanged.
- Statistics: seed=32'h12345678, 4096 enabled cycles per point:
  - I_i=0 -> fraction of ones 0.50±0.03.
  - I_i=8 -> 0.88±0.03.
  - I_i=-8 -> 0.12±0.03.
  - Every cycle also matches a bit-exact reference model of xorshift32 plus the table.
- Reset mid-operation: assert reset while enable=1 and m_i=1 -> next cycle m_i=0 and rnd = seed[31:24]. The sequence after release repeats the first run exactly.
